// File: rtl/p_bank_ctrl.sv
// p_bank_ctrl: sequences a W-bit P latch bank for two round-robin requesters.
module p_bank_ctrl #(
  parameter int W = 8,
  parameter int SETTLE = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [1:0]   req0_op,
  input  logic [W-1:0] req0_data,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [1:0]   req1_op,
  input  logic [W-1:0] req1_data,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_data,
  output logic         busy,
  output logic         p_rst,
  output logic         p_en,
  output logic [W-1:0] p_in,
  output logic [W-1:0] p_fb,
  input  logic [W-1:0] p_out
);
  typedef enum logic [2:0] {IDLE, CAPT, SETUP, PULSE, HOLD, RESP} state_t;
  localparam int CW = $clog2(SETTLE + 1);
  localparam logic [1:0] OP_CLR = 2'b00, OP_MIX = 2'b10, OP_RD = 2'b11;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] op_q, op_d;
  logic [W-1:0] data_q, data_d, fb_q, fb_d, rsp_q, rsp_d, p_in_q, p_in_d, p_fb_q, p_fb_d;
  logic id_q, id_d, last_q, last_d, p_en_q, p_en_d, p_rst_q, p_rst_d;
  logic g0, g1, acc, cnt_last, drive;
  assign g0 = req0_valid & (~req1_valid | last_q);
  assign g1 = req1_valid & (~req0_valid | ~last_q);
  assign req0_ready = (state_q == IDLE) & g0 & ~rst;
  assign req1_ready = (state_q == IDLE) & g1 & ~rst;
  assign acc = req0_ready | req1_ready;
  assign cnt_last = cnt_q == CW'(SETTLE - 1);
  assign rsp_valid = state_q == RESP;
  assign busy = state_q != IDLE;
  assign rsp_id = id_q;
  assign rsp_data = rsp_q;
  assign p_rst = p_rst_q;
  assign p_en = p_en_q;
  assign p_in = p_in_q;
  assign p_fb = p_fb_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + 1'b1;
    op_d = op_q;
    data_d = data_q;
    id_d = id_q;
    last_d = last_q;
    fb_d = fb_q;
    rsp_d = rsp_q;
    case (state_q)
      IDLE: if (acc) begin
        op_d = req1_ready ? req1_op : req0_op;
        data_d = req1_ready ? req1_data : req0_data;
        id_d = req1_ready;
        last_d = req1_ready;
        cnt_d = '0;
        state_d = op_d == OP_MIX ? CAPT : op_d == OP_RD ? HOLD : SETUP;
      end
      CAPT: if (cnt_last) begin
        fb_d = p_out;
        cnt_d = '0;
        state_d = SETUP;
      end
      SETUP: if (cnt_last) begin
        cnt_d = '0;
        state_d = PULSE;
      end
      PULSE: begin
        cnt_d = '0;
        state_d = HOLD;
      end
      HOLD: if (cnt_last) begin
        rsp_d = p_out;
        state_d = RESP;
      end
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Bank pins are computed from the next state so they are registered yet phase-aligned.
    drive = state_d == SETUP || state_d == PULSE;
    p_in_d = drive && op_d != OP_CLR ? data_d : '0;
    p_fb_d = drive && op_d == OP_MIX ? fb_d : '0;
    p_en_d = state_d == PULSE && op_d != OP_CLR;
    p_rst_d = state_d == PULSE && op_d == OP_CLR;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      op_q <= '0;
      data_q <= '0;
      id_q <= 1'b0;
      last_q <= 1'b1;
      fb_q <= '0;
      rsp_q <= '0;
      p_rst_q <= 1'b1;
      p_en_q <= 1'b0;
      p_in_q <= '0;
      p_fb_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      op_q <= op_d;
      data_q <= data_d;
      id_q <= id_d;
      last_q <= last_d;
      fb_q <= fb_d;
      rsp_q <= rsp_d;
      p_rst_q <= p_rst_d;
      p_en_q <= p_en_d;
      p_in_q <= p_in_d;
      p_fb_q <= p_fb_d;
    end
  end
endmodule

// File: tb/tb_p_bank_ctrl.sv
// tb_p_bank_ctrl: table-driven and hand-written checks of p_bank_ctrl against a P bank model.
module tb_p_bank_ctrl;
  localparam int W = 8, S = 2;
  localparam logic [1:0] CLR = 2'b00, LD = 2'b01, MX = 2'b10, RD = 2'b11;
  logic clk = 1'b0, rst = 1'b1;
  logic req0_valid = 1'b0, req1_valid = 1'b0, req0_ready, req1_ready;
  logic [1:0] req0_op = '0, req1_op = '0;
  logic [W-1:0] req0_data = '0, req1_data = '0;
  logic rsp_valid, rsp_ready = 1'b1, rsp_id, busy, p_rst, p_en;
  logic [W-1:0] rsp_data, p_in, p_fb, p_out, bank;
  always #5 clk = ~clk;
  p_bank_ctrl #(.W(W), .SETTLE(S)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_data(req1_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .busy(busy), .p_rst(p_rst), .p_en(p_en), .p_in(p_in), .p_fb(p_fb), .p_out(p_out)
  );
  // P cell bank: state loads in^fb while enabled, output is state^in.
  assign p_out = bank ^ p_in;
  always @(negedge clk) begin
    if (p_rst) bank <= '0;
    else if (p_en) bank <= p_in ^ p_fb;
  end
  int cyc = 0, tests = 0, fails = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct packed {logic id; logic [W-1:0] d;} rsp_t;
  rsp_t sb[$];
  int en_cnt = 0, rst_cnt = 0, pulse_at = -1;
  logic [W-1:0] pulse_fb = '0;
  always @(negedge clk) begin
    if (!rst) begin
      if (p_en) en_cnt++;
      if (p_rst) rst_cnt++;
      if (p_en || p_rst) begin
        pulse_at = cyc;
        pulse_fb = p_fb;
        tests++;
        if (p_en && p_rst) begin
          fails++;
          $display("FAIL en_rst_overlap: p_en=%0b p_rst=%0b, required not both high", p_en, p_rst);
        end
      end
      if (rsp_valid && rsp_ready) begin
        rsp_t e;
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_rsp: id=%0d data=0x%0h, required no response", rsp_id, rsp_data);
        end else begin
          e = sb.pop_front();
          if ({rsp_id, rsp_data} !== e) begin
            fails++;
            $display("FAIL rsp: id=%0d data=0x%0h, required id=%0d data=0x%0h", rsp_id, rsp_data, e.id, e.d);
          end
        end
      end
    end
  end
  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask
  task automatic issue(input logic id, input logic [1:0] op, input logic [W-1:0] d, output int t);
    t = -1;
    @(posedge clk);
    #1;
    if (id) begin req1_valid = 1'b1; req1_op = op; req1_data = d; end
    else begin req0_valid = 1'b1; req0_op = op; req0_data = d; end
    for (int c = 0; c < 60 && t < 0; c++) begin
      @(negedge clk);
      if (id ? req1_ready : req0_ready) t = cyc;
    end
    chk("accept", int'(t >= 0), 1);
    @(posedge clk);
    #1;
    if (id) req1_valid = 1'b0;
    else req0_valid = 1'b0;
  endtask
  task automatic wait_rsp(input int t, input int lat);
    int at = -1;
    for (int c = 0; c < 80 && at < 0; c++) begin
      @(negedge clk);
      if (rsp_valid) at = cyc;
    end
    chk("rsp_latency", at - t, lat);
  endtask
  task automatic drain;
    int c = 0;
    while ((sb.size() != 0 || busy) && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk("drain", int'(sb.size() != 0 || busy), 0);
  endtask
  typedef struct {
    logic id; logic [1:0] op; logic [W-1:0] d; logic [W-1:0] exp;
    int lat; int en; int rs; int poff; logic [W-1:0] fb;
  } vec_t;
  vec_t v[10];
  initial begin
    int t;
    logic model_last, w;
    int got;
    logic [W-1:0] bank_exp;
    v[0] = '{1'b0, LD,  8'hA5, 8'hA5, 2*S+2, 1, 0, S+1,   8'h00};
    v[1] = '{1'b0, RD,  8'h00, 8'hA5, S+1,   0, 0, 0,     8'h00};
    v[2] = '{1'b0, LD,  8'h0F, 8'h0F, 2*S+2, 1, 0, S+1,   8'h00};
    v[3] = '{1'b1, MX,  8'hF3, 8'hFC, 3*S+2, 1, 0, 2*S+1, 8'h0F};
    v[4] = '{1'b0, CLR, 8'hEE, 8'h00, 2*S+2, 0, 1, S+1,   8'h00};
    v[5] = '{1'b1, RD,  8'h00, 8'h00, S+1,   0, 0, 0,     8'h00};
    v[6] = '{1'b1, LD,  8'h3C, 8'h3C, 2*S+2, 1, 0, S+1,   8'h00};
    v[7] = '{1'b0, MX,  8'h55, 8'h69, 3*S+2, 1, 0, 2*S+1, 8'h3C};
    v[8] = '{1'b1, MX,  8'hFF, 8'h96, 3*S+2, 1, 0, 2*S+1, 8'h69};
    v[9] = '{1'b1, RD,  8'h00, 8'h96, S+1,   0, 0, 0,     8'h00};
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("reset_outs", int'({p_rst, p_en, p_in, p_fb, rsp_valid, rsp_id, rsp_data, busy, req0_ready, req1_ready}),
          int'(32'h4000_0000));
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    req0_valid = 1'b1;
    req0_op = RD;
    sb.push_back('{1'b0, 8'h00});
    @(negedge clk);
    chk("first_ready0", int'(req0_ready), 1);
    chk("p_rst_released", int'(p_rst), 0);
    t = cyc;
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    wait_rsp(t, S+1);
    model_last = 1'b0;
    bank_exp = '0;
    for (int i = 0; i < 10; i++) begin
      en_cnt = 0;
      rst_cnt = 0;
      pulse_at = -1;
      pulse_fb = '0;
      sb.push_back('{v[i].id, v[i].exp});
      issue(v[i].id, v[i].op, v[i].d, t);
      model_last = v[i].id;
      wait_rsp(t, v[i].lat);
      chk("en_pulses", en_cnt, v[i].en);
      chk("rst_pulses", rst_cnt, v[i].rs);
      if (v[i].poff > 0) begin
        chk("pulse_cycle", pulse_at - t, v[i].poff);
        chk("pulse_fb", int'(pulse_fb), int'(v[i].fb));
      end
      bank_exp = v[i].exp;
    end
    drain();
    @(posedge clk);
    #1;
    req0_op = RD;
    req1_op = RD;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      w = model_last ? 1'b0 : 1'b1;
      got = -1;
      for (int c = 0; c < 40 && got < 0; c++) begin
        @(negedge clk);
        if (req0_ready || req1_ready) got = int'(req1_ready);
      end
      chk("grant", got, int'(w));
      chk("grant_excl", int'(req0_ready & req1_ready), 0);
      sb.push_back('{w, bank_exp});
      model_last = w;
      @(posedge clk);
      #1;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    drain();
    @(posedge clk);
    #1;
    req1_valid = 1'b1;
    req1_op = RD;
    @(negedge clk);
    chk("lone_req1", int'(req1_ready), 1);
    sb.push_back('{1'b1, bank_exp});
    @(posedge clk);
    #1;
    req1_valid = 1'b0;
    model_last = 1'b1;
    drain();
    rsp_ready = 1'b0;
    sb.push_back('{1'b0, 8'h5A});
    issue(1'b0, LD, 8'h5A, t);
    wait_rsp(t, 2*S+2);
    @(posedge clk);
    #1;
    req1_valid = 1'b1;
    req1_op = RD;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_hold", int'({rsp_valid, rsp_id, rsp_data, req0_ready, req1_ready, busy}),
          int'({1'b1, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b1}));
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    sb.push_back('{1'b1, 8'h5A});
    @(negedge clk);
    @(negedge clk);
    chk("accept_after_hs", int'(req1_ready), 1);
    @(posedge clk);
    #1;
    req1_valid = 1'b0;
    drain();
    issue(1'b0, LD, 8'h77, t);
    got = -1;
    for (int c = 0; c < 20 && got < 0; c++) begin
      @(negedge clk);
      if (p_en) got = 1;
    end
    chk("saw_pulse", got, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_pulse", int'({busy, p_en, p_rst, rsp_valid}), int'(4'b0010));
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("no_rsp_after_rst", int'(rsp_valid), 0);
    sb.push_back('{1'b0, 8'h00});
    issue(1'b0, RD, 8'h00, t);
    wait_rsp(t, S+1);
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL timeout: simulation still running, required completion");
    $fatal(1);
  end
endmodule
